mem_2r2w_arbiter: RTL
=====================

Name: mem_2r2w_arbiter

Overview:
- Shares one two-port 16384x32 RAM (ports A and B, registered read, write-through on write) among NUM_REQ requesters.
- Each cycle, grants up to two requests by round robin: first winner to port A, second to port B.
- Steers the RAM's 1-cycle-late data back to the owning requester.
- Sits between client engines and the RAM instance; RAM clocks clk_a and clk_b are both tied to clk.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_W, 14, RAM address width.
- DATA_W, 32, RAM data width.
- ID_W, 2, requester index width; must equal clog2(NUM_REQ).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester grant; combinational.
- req_wen  in  NUM_REQ  1 = write, 0 = read.
- req_addr  in  NUM_REQ*ADDR_W  flattened addresses; requester i at slice i.
- req_wdata  in  NUM_REQ*DATA_W  flattened write data.
- rsp_valid  out  NUM_REQ  response strobe, 1 cycle.
- rsp_data  out  NUM_REQ*DATA_W  response data; read data, or write data echo.
- mem_wen_a  out  1  to RAM port A.
- mem_addr_a  out  ADDR_W  to RAM port A.
- mem_wdata_a  out  DATA_W  to RAM port A.
- mem_rdata_a  in  DATA_W  from RAM port A (registered in RAM).
- mem_wen_b, mem_addr_b, mem_wdata_b, mem_rdata_b: same as port A, for port B.

Behaviour:
- Transfer: a request is accepted when req_valid[i] && req_ready[i] in the same cycle. Requester holds valid/wen/addr/wdata stable until accepted.
- Arbitration (combinational, state = rr_ptr of ID_W bits):
  - Port A winner = first valid index scanning rr_ptr, rr_ptr+1, … mod NUM_REQ.
  - Port B winner = next valid index after the A winner in the same rotation.
- Collision rule: B grant is withheld that cycle when addr(A) == addr(B) and either request is a write. Same-address read/read is allowed.
- At most two req_ready bits are high per cycle, never the same index twice.
- Port drive when a port has a grant: mem_wen_x = req_wen, mem_addr_x = req_addr, mem_wdata_x = req_wdata.
- Port drive when ungranted: mem_wen_x = 0, addr = 0, wdata = 0.
- rr_ptr update (registered): becomes (last granted index + 1) mod NUM_REQ, where last granted = B winner if granted, else A winner. Unchanged when nothing is granted.
- Tag pipeline (registered): tag_v_a, tag_id_a, tag_v_b, tag_id_b capture each port's grant.
- Response:
  - Cycle after accept: rsp_valid[tag_id_x] = 1 and rsp_data slice = mem_rdata_x.
  - Fixed latency 1; no response backpressure.
  - Writes also return a response (data echo). Unselected rsp_data slices are 0.
- Back-to-back: a requester may be granted on consecutive cycles; responses then arrive on consecutive cycles.
- Reset values: rr_ptr=0, tag_v_a/b=0, rsp_valid=0, rsp_data=0.
- During rst: req_ready=0 and mem_wen_a/b=0, forced.
- Reset mid-operation: in-flight responses are dropped.
- Single requester only: uses port A each cycle; port B idle.

Optional Feature:
- Macro: MEM_ARB_PERF_CNT_EN.
- When defined:
  - Adds output perf_grant_cnt, NUM_REQ*16 bits: per-requester 16-bit saturating count of accepted requests.
  - Adds output perf_collide_cnt, 16 bits: saturating count of cycles where B was withheld by the collision rule.
  - Counters reset to 0 on rst.
- When undefined: neither port nor the counter logic exists.

Decomposition:
- Package mem_arb_pkg holds:
  - constants MEM_DEPTH=16384, MEM_ADDR_W=14, MEM_DATA_W=32;
  - the rsp tag struct {valid, id};
  - the round-robin next-index function.
- One natural sub-module, rr_pick2: combinational two-winner round-robin picker. Inputs: valid vector, rr_ptr. Outputs: A/B one-hot plus indices. The collision mask is applied in the parent.

Test Plan:
- Reset: hold rst with all req_valid=1 -> req_ready=0, mem_wen=0, rsp_valid=0. After release, first grants go to A=0, B=1.
- Four requesters reading distinct addrs 0x10..0x13 continuously -> grants 0/1, 2/3, 0/1…. Each rsp_valid arrives one cycle after its grant with the preloaded words.
- Req0 writes 0x0ABC=0xDEADBEEF and req1 reads 0x0ABC in the same cycle -> only req0 granted. Req1 granted next cycle and reads 0xDEADBEEF. perf_collide_cnt=1 when the macro is defined.
- Req2 and req3 read the same addr 0x3FFF -> both granted the same cycle, both receive the identical word.
- Only req3 valid with a write of 0x12345678 -> port A used, port B idle. Next cycle rsp_valid[3]=1 with echo 0x12345678. rr_ptr wraps to 0.
- rst asserted the cycle after a grant -> no rsp_valid. rr_ptr returns to 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port RAM arbiter: RAM geometry,
// the response tag carried alongside each port's read, and the
// round-robin successor function used by both picker and pointer update.
package mem_arb_pkg;

  localparam int MEM_DEPTH  = 16384;
  localparam int MEM_ADDR_W = 14;
  localparam int MEM_DATA_W = 32;

  // Tag id is wide enough for the largest supported requester count (8).
  localparam int TAG_ID_W = 3;

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } rsp_tag_t;

  // Next index in the rotation, wrapping at num (num in 2..8).
  function automatic logic [TAG_ID_W-1:0] rr_next(input logic [TAG_ID_W-1:0] idx,
                                                  input logic [TAG_ID_W:0]   num);
    logic [TAG_ID_W:0] inc;
    inc = {1'b0, idx} + {{TAG_ID_W{1'b0}}, 1'b1};
    if (inc >= num) begin
      return {TAG_ID_W{1'b0}};
    end else begin
      return inc[TAG_ID_W-1:0];
    end
  endfunction

endpackage

// File: rtl/mem_2r2w_arbiter_rr_pick2.sv
// rr_pick2: combinational two-winner round-robin picker. Scans the valid
// vector starting at rr_ptr; the first valid index wins port A and the next
// valid index in the same rotation wins port B. No collision masking here.
module rr_pick2
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [NUM_REQ-1:0] oh_a,
  output logic [NUM_REQ-1:0] oh_b,
  output logic [ID_W-1:0]    idx_a,
  output logic [ID_W-1:0]    idx_b,
  output logic               found_a,
  output logic               found_b
);

  localparam int                EXT_W     = 1 << TAG_ID_W;
  localparam logic [TAG_ID_W:0] NUM_REQ_L = (TAG_ID_W+1)'(NUM_REQ);

  logic [EXT_W-1:0]    valid_ext_s;
  logic [TAG_ID_W-1:0] idx_a_ext_s;
  logic [TAG_ID_W-1:0] idx_b_ext_s;

  // Pad the valid vector so the scan counter indexes it at full width.
  always_comb begin
    valid_ext_s                = {EXT_W{1'b0}};
    valid_ext_s[NUM_REQ-1:0]   = valid;
  end

  // Walk the rotation once: first hit goes to A, second hit goes to B.
  always_comb begin
    logic [TAG_ID_W-1:0] cand_s;
    found_a     = 1'b0;
    found_b     = 1'b0;
    idx_a_ext_s = {TAG_ID_W{1'b0}};
    idx_b_ext_s = {TAG_ID_W{1'b0}};
    cand_s      = TAG_ID_W'(rr_ptr);
    for (int k = 0; k < NUM_REQ; k++) begin
      if (valid_ext_s[cand_s] && !found_a) begin
        found_a     = 1'b1;
        idx_a_ext_s = cand_s;
      end else if (valid_ext_s[cand_s] && !found_b) begin
        found_b     = 1'b1;
        idx_b_ext_s = cand_s;
      end else begin
        found_b = found_b;
      end
      cand_s = rr_next(cand_s, NUM_REQ_L);
    end
  end

  // Narrow indices and expand to one-hot grant vectors.
  always_comb begin
    idx_a = ID_W'(idx_a_ext_s);
    idx_b = ID_W'(idx_b_ext_s);
    oh_a  = {NUM_REQ{1'b0}};
    oh_b  = {NUM_REQ{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      oh_a[i] = found_a && (idx_a_ext_s == TAG_ID_W'(i));
      oh_b[i] = found_b && (idx_b_ext_s == TAG_ID_W'(i));
    end
  end

endmodule

// File: rtl/mem_2r2w_arbiter.sv
// mem_2r2w_arbiter: shares one two-port RAM (registered read, write-through)
// among NUM_REQ requesters. Up to two grants per cycle by round robin
// (first winner on port A, second on port B); port B is withheld when both
// winners hit the same address and either one writes. The RAM's data, one
// cycle later, is steered back to the owning requester using a small tag
// pipeline.
// Optional: define MEM_ARB_PERF_CNT_EN to add saturating grant and
// collision counters (perf_grant_cnt, perf_collide_cnt).
module mem_2r2w_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 14,
  parameter int DATA_W  = 32,
  parameter int ID_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_wen,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [NUM_REQ*DATA_W-1:0] rsp_data,
  output logic                      mem_wen_a,
  output logic [ADDR_W-1:0]         mem_addr_a,
  output logic [DATA_W-1:0]         mem_wdata_a,
  input  logic [DATA_W-1:0]         mem_rdata_a,
  output logic                      mem_wen_b,
  output logic [ADDR_W-1:0]         mem_addr_b,
  output logic [DATA_W-1:0]         mem_wdata_b,
  input  logic [DATA_W-1:0]         mem_rdata_b
`ifdef MEM_ARB_PERF_CNT_EN
  ,
  output logic [NUM_REQ*16-1:0]     perf_grant_cnt,
  output logic [15:0]               perf_collide_cnt
`endif
);

  localparam logic [TAG_ID_W:0] NUM_REQ_L = (TAG_ID_W+1)'(NUM_REQ);

  logic [ADDR_W-1:0]  addr_arr_s  [NUM_REQ];
  logic [DATA_W-1:0]  wdata_arr_s [NUM_REQ];
  logic [NUM_REQ-1:0] oh_a_s;
  logic [NUM_REQ-1:0] oh_b_s;
  logic [ID_W-1:0]    idx_a_s;
  logic [ID_W-1:0]    idx_b_s;
  logic               found_a_s;
  logic               found_b_s;
  logic               collide_s;
  logic               gnt_a_s;
  logic               gnt_b_s;
  logic [ID_W-1:0]    last_idx_s;
  logic [ID_W-1:0]    rr_ptr_r;
  rsp_tag_t           tag_a_r;
  rsp_tag_t           tag_b_r;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_arr_s[g]  = req_addr[g*ADDR_W +: ADDR_W];
    assign wdata_arr_s[g] = req_wdata[g*DATA_W +: DATA_W];
  end

  rr_pick2 #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .valid   (req_valid),
    .rr_ptr  (rr_ptr_r),
    .oh_a    (oh_a_s),
    .oh_b    (oh_b_s),
    .idx_a   (idx_a_s),
    .idx_b   (idx_b_s),
    .found_a (found_a_s),
    .found_b (found_b_s)
  );

  // Grant qualification: same-address pair with any write loses its B grant;
  // nothing is granted while reset is held.
  always_comb begin
    collide_s  = found_a_s && found_b_s &&
                 (addr_arr_s[idx_a_s] == addr_arr_s[idx_b_s]) &&
                 (req_wen[idx_a_s] || req_wen[idx_b_s]);
    gnt_a_s    = found_a_s && !rst;
    gnt_b_s    = found_b_s && !collide_s && !rst;
    last_idx_s = gnt_b_s ? idx_b_s : idx_a_s;
  end

  // Drive ready strobes and both RAM ports from the qualified grants.
  always_comb begin
    req_ready   = {NUM_REQ{1'b0}};
    mem_wen_a   = 1'b0;
    mem_addr_a  = {ADDR_W{1'b0}};
    mem_wdata_a = {DATA_W{1'b0}};
    mem_wen_b   = 1'b0;
    mem_addr_b  = {ADDR_W{1'b0}};
    mem_wdata_b = {DATA_W{1'b0}};
    if (gnt_a_s) begin
      req_ready   = req_ready | oh_a_s;
      mem_wen_a   = req_wen[idx_a_s];
      mem_addr_a  = addr_arr_s[idx_a_s];
      mem_wdata_a = wdata_arr_s[idx_a_s];
    end else begin
      mem_wen_a   = 1'b0;
    end
    if (gnt_b_s) begin
      req_ready   = req_ready | oh_b_s;
      mem_wen_b   = req_wen[idx_b_s];
      mem_addr_b  = addr_arr_s[idx_b_s];
      mem_wdata_b = wdata_arr_s[idx_b_s];
    end else begin
      mem_wen_b   = 1'b0;
    end
  end

  // Round-robin pointer: restart the scan just after the last granted index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_r <= {ID_W{1'b0}};
    end else if (gnt_a_s) begin
      rr_ptr_r <= ID_W'(rr_next(TAG_ID_W'(last_idx_s), NUM_REQ_L));
    end else begin
      rr_ptr_r <= rr_ptr_r;
    end
  end

  // Tag pipeline: remember who owns each port's data arriving next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_a_r <= '{valid: 1'b0, id: {TAG_ID_W{1'b0}}};
      tag_b_r <= '{valid: 1'b0, id: {TAG_ID_W{1'b0}}};
    end else begin
      tag_a_r <= '{valid: gnt_a_s, id: TAG_ID_W'(idx_a_s)};
      tag_b_r <= '{valid: gnt_b_s, id: TAG_ID_W'(idx_b_s)};
    end
  end

  // Steer RAM read data to the tagged requester; unselected slices stay zero.
  always_comb begin
    rsp_valid = {NUM_REQ{1'b0}};
    rsp_data  = {(NUM_REQ*DATA_W){1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      if (tag_a_r.valid && (tag_a_r.id == TAG_ID_W'(i))) begin
        rsp_valid[i]                = 1'b1;
        rsp_data[i*DATA_W +: DATA_W] = mem_rdata_a;
      end else if (tag_b_r.valid && (tag_b_r.id == TAG_ID_W'(i))) begin
        rsp_valid[i]                = 1'b1;
        rsp_data[i*DATA_W +: DATA_W] = mem_rdata_b;
      end else begin
        rsp_valid[i] = 1'b0;
      end
    end
  end

`ifdef MEM_ARB_PERF_CNT_EN
  // Per-requester saturating count of accepted requests.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_grant_cnt <= {(NUM_REQ*16){1'b0}};
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && req_ready[i] && (perf_grant_cnt[i*16 +: 16] != 16'hFFFF)) begin
          perf_grant_cnt[i*16 +: 16] <= perf_grant_cnt[i*16 +: 16] + 16'd1;
        end else begin
          perf_grant_cnt[i*16 +: 16] <= perf_grant_cnt[i*16 +: 16];
        end
      end
    end
  end

  // Saturating count of cycles where port B lost its grant to a collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_collide_cnt <= 16'd0;
    end else if (collide_s && (perf_collide_cnt != 16'hFFFF)) begin
      perf_collide_cnt <= perf_collide_cnt + 16'd1;
    end else begin
      perf_collide_cnt <= perf_collide_cnt;
    end
  end
`endif

endmodule
